// File: rtl/mulf_seq.sv
// mulf_seq: iterative 1-8-7 float multiplier; shift-add mantissa product, valid/ready on both sides.
// Optional ROUND_NEAREST_EN: round-to-nearest-even in NORM instead of truncation.
module mulf_seq #(
   parameter int BIAS  = 127,
   parameter int MBITS = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        ovf,
   output logic        unf,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
   state_t      r_state;
   logic        r_sign;
   logic [7:0]  r_ea, r_eb, r_ma, r_mb;
   logic [15:0] r_prod;
   logic [2:0]  r_cnt;
   logic [15:0] r_result;
   logic        r_ovf, r_unf, r_out_valid;
   logic        w_hi;
   logic [6:0]  w_mant7, w_mant;
   logic [9:0]  w_e, w_ef;
   logic        w_zero, w_big, w_small;
   assign w_hi    = r_prod[15];
   assign w_mant7 = w_hi ? r_prod[14:8] : r_prod[13:7];
   assign w_e     = {2'b0, r_ea} + {2'b0, r_eb} - 10'(BIAS) + {9'b0, w_hi};
`ifdef ROUND_NEAREST_EN
   logic       w_guard, w_sticky, w_up;
   logic [7:0] w_rnd;
   assign w_guard  = w_hi ? r_prod[7] : r_prod[6];
   assign w_sticky = w_hi ? |r_prod[6:0] : |r_prod[5:0];
   assign w_up     = w_guard & (w_sticky | w_mant7[0]);
   assign w_rnd    = {1'b0, w_mant7} + {7'b0, w_up};
   assign w_mant   = w_rnd[6:0];
   // carry out of the mantissa bumps the exponent before the range checks
   assign w_ef     = w_e + {9'b0, w_rnd[7]};
`else
   assign w_mant   = w_mant7;
   assign w_ef     = w_e;
`endif
   assign w_zero  = (r_ea == 8'd0) || (r_eb == 8'd0);
   assign w_big   = $signed(w_ef) >= 10'sd255;
   assign w_small = $signed(w_ef) <= 10'sd0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sign      <= 1'b0;
         r_ea        <= 8'd0;
         r_eb        <= 8'd0;
         r_ma        <= 8'd0;
         r_mb        <= 8'd0;
         r_prod      <= 16'd0;
         r_cnt       <= 3'd0;
         r_result    <= 16'd0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_sign  <= a[15] ^ b[15];
               r_ea    <= a[14:7];
               r_eb    <= b[14:7];
               r_ma    <= {1'b1, a[6:0]};
               r_mb    <= {1'b1, b[6:0]};
               r_prod  <= 16'd0;
               r_cnt   <= 3'd0;
               r_state <= MUL;
            end
            MUL: begin
               if (r_mb[r_cnt]) r_prod <= r_prod + ({8'd0, r_ma} << r_cnt);
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) r_state <= NORM;
            end
            NORM: begin
               r_ovf       <= !w_zero && w_big;
               r_unf       <= !w_zero && !w_big && w_small;
               r_result    <= w_zero || w_small && !w_big ? {r_sign, 15'd0} :
                              w_big ? {r_sign, 8'hFF, 7'h00} :
                              {r_sign, w_ef[7:0], w_mant[MBITS-1:0]};
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end
   assign in_ready  = r_state == IDLE;
   assign busy      = r_state != IDLE;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign ovf       = r_ovf;
   assign unf       = r_unf;
endmodule

// File: tb/tb_mulf_seq.sv
// tb_mulf_seq: directed vectors for mulf_seq, checked against an arithmetic model and literals.
module tb_mulf_seq;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] a = 16'd0, b = 16'd0;
   logic        in_ready, out_valid, ovf, unf, busy;
   logic [15:0] result;
   logic [17:0] exp_q[$];
   int          errors = 0, checks = 0;

   mulf_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf), .unf(unf), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // returns {ovf, unf, result} from the real-valued product m_a*m_b*2^(ea+eb-2*127)
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
      int ex = int'(x[14:7]);
      int ey = int'(y[14:7]);
      int p  = (128 + int'(x[6:0])) * (128 + int'(y[6:0]));
      int sh = (p >= 32768) ? 8 : 7;
      int e  = ex + ey - 127 + sh - 7;
      int m  = p >> sh;
      logic s = x[15] ^ y[15];
`ifdef ROUND_NEAREST_EN
      int rem  = p % (1 << sh);
      int half = 1 << (sh - 1);
      if (rem > half || (rem == half && (m % 2) == 1)) m++;
      if (m == 256) begin
         m = 128;
         e++;
      end
`endif
      if (ex == 0 || ey == 0) return {2'b00, s, 15'd0};
      if (e >= 255) return {2'b10, s, 8'hFF, 7'h00};
      if (e <= 0) return {2'b01, s, 15'd0};
      return {2'b00, s, 8'(e), 7'(m)};
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("scoreboard", {14'd0, ovf, unf, result}, {14'd0, exp_q[0]});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int stall, input logic [17:0] lit);
      int n = 0;
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      chk("model_pin", {14'd0, model(x, y)}, {14'd0, lit});
      a = x;
      b = y;
      in_valid = 1'b1;
      out_ready = (stall == 0);
      exp_q.push_back(model(x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("edges_accept_to_valid", n, 32'd9);
      chk("result_literal", {14'd0, ovf, unf, result}, {14'd0, lit});
      repeat (stall) begin
         @(posedge clk); #1;
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_result", {16'd0, result}, {16'd0, lit[15:0]});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_flags", {30'd0, ovf, unf}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h4040, 16'h4040, 0, 18'h04110);
      run_op(16'hC040, 16'h4000, 5, 18'h0C0C0);
      run_op(16'h7F00, 16'h4000, 0, 18'h27F80);
      run_op(16'h0080, 16'h0080, 0, 18'h10000);
      run_op(16'h0000, 16'h4040, 0, 18'h00000);
      run_op(16'hBF80, 16'h0000, 2, 18'h08000);
`ifdef ROUND_NEAREST_EN
      run_op(16'h3FC1, 16'h3FC1, 0, 18'h04012);
`else
      run_op(16'h3FC1, 16'h3FC1, 0, 18'h04011);
`endif
      a = 16'h4040;
      b = 16'h4040;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("busy_in_mul", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h3F80, 16'h4040, 0, 18'h04040);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
